fetch: RTL

Instruction fetch stage of the ppcpu pipeline, directly upstream of `decode`. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Fetched 32-bit instructions go into a small prefetch buffer. From there they are handed to `decode` as a low half-word (`o_instr_l`) plus an immediate pass-through (`o_imm_pass`), under decode's `i_next_ready`/`o_submit` protocol. It also accepts PC redirects from execute and flushes everything fetched down the wrong path.

---
 rtl/fetch_if.sv | 30 +++
 rtl/fetch.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port, the decode-side
// submit port and the execute redirect port, grouped into one interface.
// The master modport is the fetch stage; the slave modport is its environment.
`ifndef I_SIZE
`define I_SIZE 32
`endif

interface fetch_if;
  logic                o_mem_req;
  logic [15:0]         o_mem_addr;
  logic                i_mem_ack;
  logic [`I_SIZE-1:0]  i_mem_data;
  logic                i_next_ready;
  logic                o_submit;
  logic [15:0]         o_instr_l;
  logic [`I_SIZE-17:0] o_imm_pass;
  logic [15:0]         o_pc;
  logic                i_pc_ie;
  logic [15:0]         i_pc_val;

  modport master (
    output o_mem_req, o_mem_addr, o_submit, o_instr_l, o_imm_pass, o_pc,
    input  i_mem_ack, i_mem_data, i_next_ready, i_pc_ie, i_pc_val
  );

  modport slave (
    input  o_mem_req, o_mem_addr, o_submit, o_instr_l, o_imm_pass, o_pc,
    output i_mem_ack, i_mem_data, i_next_ready, i_pc_ie, i_pc_val
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues word reads over req/ack,
// buffers fetched words and hands them to decode one per o_submit pulse.
// Redirects from execute flush the buffer; a read already in flight at the
// time of a redirect is marked stale and its data dropped when it returns.
// Build option FETCH_PREFETCH_EN: two-entry buffer allowing a new read while
// one word is buffered (1 IPC on zero-wait memory); otherwise one entry.
`ifndef I_SIZE
`define I_SIZE 32
`endif

module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  fetch_if.master bus
);

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int ISZ = `I_SIZE;
  // Buffer entry layout: {instruction word, address}
  localparam int EW  = ISZ + 16;

  logic                 r_req;
  logic [15:0]          r_addr;
  logic [15:0]          r_pc;
  logic                 r_stale;
  logic [1:0]           r_cnt;
  logic [DEPTH*EW-1:0]  r_buf;
  logic                 r_submit;
  logic [15:0]          r_instr_l;
  logic [ISZ-17:0]      r_imm;
  logic [15:0]          r_opc;

  logic                 w_ack;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_pend_nxt;
  logic                 w_issue;
  logic [1:0]           w_cnt_nxt;
  logic [1:0]           w_wr_idx;
  logic [15:0]          w_pc_nxt;
  logic [DEPTH*EW-1:0]  w_buf_nxt;
  logic [EW-1:0]        w_head;

  // Next-state control: redirect overrides push, pop and PC advance.
  always_comb begin
    w_ack      = r_req & bus.i_mem_ack;
    w_push     = w_ack & ~r_stale & ~bus.i_pc_ie;
    w_pop      = ~bus.i_pc_ie & bus.i_next_ready & (r_cnt != 2'd0);
    w_pend_nxt = r_req & ~bus.i_mem_ack;
    if (bus.i_pc_ie)
      w_cnt_nxt = 2'd0;
    else
      w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    if (bus.i_pc_ie)
      w_pc_nxt = bus.i_pc_val;
    else if (w_push)
      w_pc_nxt = r_pc + 16'd1;
    else
      w_pc_nxt = r_pc;
    // Room is judged on post-update occupancy so an ack and a new request
    // can overlap back to back.
    w_issue = ~w_pend_nxt & (w_cnt_nxt < 2'(DEPTH));
  end

  // Buffer next value: head at slot 0, pop shifts down, push lands behind.
  always_comb begin
    w_head    = r_buf[EW-1:0];
    w_wr_idx  = r_cnt - {1'b0, w_pop};
    w_buf_nxt = w_pop ? (r_buf >> EW) : r_buf;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && (w_wr_idx == 2'(i)))
        w_buf_nxt[i*EW +: EW] = {bus.i_mem_data, r_pc};
    end
  end

  // Buffer storage; occupancy tracking makes a data reset unnecessary.
  always_ff @(posedge i_clk) begin
    r_buf <= w_buf_nxt;
  end

  // PC, request handshake, stale flag and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_pc    <= RESET_PC;
      r_stale <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_cnt <= w_cnt_nxt;
      if (bus.i_pc_ie)
        r_stale <= w_pend_nxt;
      else if (w_ack)
        r_stale <= 1'b0;
      // An outstanding request holds its address until acked.
      if (w_issue) begin
        r_req  <= 1'b1;
        r_addr <= w_pc_nxt;
      end else if (!w_pend_nxt) begin
        r_req  <= 1'b0;
      end
    end
  end

  // Registered submit port towards decode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_submit  <= 1'b0;
      r_instr_l <= 16'h0000;
      r_imm     <= '0;
      r_opc     <= 16'h0000;
    end else begin
      r_submit <= w_pop;
      if (w_pop) begin
        r_instr_l <= w_head[31:16];
        r_imm     <= w_head[EW-1:32];
        r_opc     <= w_head[15:0];
      end
    end
  end

  assign bus.o_mem_req  = r_req;
  assign bus.o_mem_addr = r_addr;
  assign bus.o_submit   = r_submit;
  assign bus.o_instr_l  = r_instr_l;
  assign bus.o_imm_pass = r_imm;
  assign bus.o_pc       = r_opc;

endmodule
